// File: rtl/instruction_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetch
// Brief    : Pipelined instruction fetch keeping several sequential bus reads
//            in flight and buffering returned words with their PCs in a FIFO.
//            Optional macro INSTRUCTION_PREFETCH_BYPASS_EN forwards a return
//            straight to the consumer when the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_prefetch #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        system_bus_ready,
    output logic [31:0] system_bus_addr,
    output logic [3:0]  system_bus_byte_enable,
    output logic        system_bus_read_req,
    input  logic [31:0] system_bus_read_data,
    input  logic        system_bus_read_data_valid
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_INF_W = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_return_pc;
    logic [c_INF_W-1:0] r_inflight;
    logic [c_INF_W-1:0] r_discard;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [31:0]        r_mem_data [DEPTH];
    logic [31:0]        r_mem_pc   [DEPTH];

    logic [31:0]        w_credit_used;
    logic [31:0]        w_redirect_pc;
    logic               w_read_req;
    logic               w_accept;
    logic               w_ret;
    logic               w_keep;
    logic               w_head_valid;
    logic               w_bypass_vis;
    logic               w_bypass_take;
    logic               w_push;
    logic               w_pop;
    logic [c_INF_W-1:0] w_inflight_nxt;
    logic [c_INF_W-1:0] w_discard_nxt;

    // Words still owed to the FIFO (non-discarded in-flight) plus those already
    // buffered must stay below DEPTH, so the FIFO can never overflow.
    assign w_credit_used = 32'(r_inflight - r_discard) + 32'(r_count);
    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    assign w_read_req = !reset && !redirect_valid
                        && (32'(r_inflight) < 32'(MAX_OUTSTANDING))
                        && (w_credit_used < 32'(DEPTH));
    assign w_accept   = w_read_req && system_bus_ready;
    assign w_ret      = !reset && system_bus_read_data_valid && (r_inflight != '0);
    assign w_keep     = w_ret && (r_discard == '0) && !redirect_valid;
    assign w_head_valid = (r_count != '0);

`ifdef INSTRUCTION_PREFETCH_BYPASS_EN
    assign w_bypass_vis  = w_keep && !w_head_valid;
    assign w_bypass_take = w_bypass_vis && instr_ready;
`else
    assign w_bypass_vis  = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    assign w_push = w_keep && !w_bypass_take;
    assign w_pop  = w_head_valid && instr_ready && !redirect_valid;

    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_accept, w_ret})
            2'b10:   w_inflight_nxt = r_inflight + c_INF_W'(1);
            2'b01:   w_inflight_nxt = r_inflight - c_INF_W'(1);
            default: w_inflight_nxt = r_inflight;
        endcase

        // A redirect marks everything still outstanding as stale.
        w_discard_nxt = r_discard;
        if (redirect_valid) begin
            w_discard_nxt = w_inflight_nxt;
        end else if (w_ret && (r_discard != '0)) begin
            w_discard_nxt = r_discard - c_INF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc  <= RESET_PC;
            r_return_pc <= RESET_PC;
            r_inflight  <= '0;
            r_discard   <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_discard  <= w_discard_nxt;
            if (redirect_valid) begin
                r_fetch_pc  <= w_redirect_pc;
                r_return_pc <= w_redirect_pc;
                r_count     <= '0;
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_keep) begin
                    r_return_pc <= r_return_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= system_bus_read_data;
            r_mem_pc[r_wr_ptr]   <= r_return_pc;
        end
    end

    assign system_bus_addr        = r_fetch_pc;
    assign system_bus_byte_enable = 4'hf;
    assign system_bus_read_req    = w_read_req;

    assign instr_valid = w_head_valid || w_bypass_vis;
    assign instr_data  = w_bypass_vis ? system_bus_read_data
                       : (w_head_valid ? r_mem_data[r_rd_ptr] : 32'h0);
    assign instr_pc    = w_bypass_vis ? r_return_pc
                       : (w_head_valid ? r_mem_pc[r_rd_ptr] : 32'h0);

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(w_push && !w_pop && (r_count == c_CNT_W'(DEPTH))));
    a_discard_bound : assert property (@(posedge clk) disable iff (reset)
        r_discard <= r_inflight);
    a_inflight_bound : assert property (@(posedge clk) disable iff (reset)
        32'(r_inflight) <= 32'(MAX_OUTSTANDING));

endmodule
`default_nettype wire
